// File: rtl/program_loader_if.sv
// Host byte stream plus instruction-memory write port of the program loader.
// The slave modport is the loader's view; the master modport is the host/memory side.
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 24
);
  logic [7:0]        byte_dat;
  logic              byte_vld;
  logic              byte_rdy;
  logic              im_wr_en;
  logic [ADDR_W-1:0] im_addr;
  logic [INS_W-1:0]  im_wr_dat;

  modport master (
    output byte_dat, byte_vld,
    input  byte_rdy, im_wr_en, im_addr, im_wr_dat
  );

  modport slave (
    input  byte_dat, byte_vld,
    output byte_rdy, im_wr_en, im_addr, im_wr_dat
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader (len, 3 bytes/word MSB first, XOR csum) into instruction memory.
// Write strobe 1 cycle after the last byte of a word; byte_rdy is low outside receiving states.
module program_loader #(
  parameter int ADDR_W = 8,
  parameter int INS_W  = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  program_loader_if.slave        bus,
  output logic                   cpu_hold_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_B2, S_B1, S_B0, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [INS_W-1:0]  word_q, word_d;
  logic [ADDR_W-1:0] addr_inc;
  logic              xfer;

  assign xfer     = bus.byte_vld && bus.byte_rdy;
  assign addr_inc = addr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR;
          addr_d  = '0;
          csum_d  = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          cnt_d   = bus.byte_dat;
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (xfer) begin
          word_d[23:16] = bus.byte_dat;
          csum_d        = csum_q ^ bus.byte_dat;
          state_d       = S_B1;
        end
      end
      S_B1: begin
        if (xfer) begin
          word_d[15:8] = bus.byte_dat;
          csum_d       = csum_q ^ bus.byte_dat;
          state_d      = S_B0;
        end
      end
      S_B0: begin
        if (xfer) begin
          word_d[7:0] = bus.byte_dat;
          csum_d      = csum_q ^ bus.byte_dat;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        // Address doubles as the words-written count; a zero header wraps to match after 2^ADDR_W words.
        addr_d  = addr_inc;
        state_d = (addr_inc == cnt_q) ? S_CSUM : S_B2;
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (bus.byte_dat == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_rdy  = (state_q == S_HDR) || (state_q == S_B2) || (state_q == S_B1) ||
                         (state_q == S_B0)  || (state_q == S_CSUM);
  assign bus.im_wr_en  = (state_q == S_WRITE);
  assign bus.im_addr   = addr_q;
  assign bus.im_wr_dat = word_q;

  assign busy_o     = bus.byte_rdy || (state_q == S_WRITE);
  assign cpu_hold_o = (state_q != S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = (state_q == S_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, checksum error, wrap, stalls and reset abort.
module tb_program_loader;

  logic clk;
  logic rst_n;
  logic start;
  logic cpu_hold, busy, done, err;

  program_loader_if #(.ADDR_W(8), .INS_W(24)) bus ();

  program_loader #(.ADDR_W(8), .INS_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .bus        (bus),
    .cpu_hold_o (cpu_hold),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  wr_addr_q[$];
  logic [23:0] wr_dat_q[$];
  int          wr_viol;
  logic [7:0]  exp_addr_q[$];
  logic [23:0] exp_dat_q[$];
  logic [7:0]  payload_q[$];

  always @(negedge clk) begin
    if (bus.im_wr_en) begin
      wr_addr_q.push_back(bus.im_addr);
      wr_dat_q.push_back(bus.im_wr_dat);
      if (bus.byte_rdy || !busy) wr_viol++;
    end
  end

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gaps);
    int t;
    for (int g = 0; g < gaps; g++) begin
      bus.byte_vld = 1'b0;
      bus.byte_dat = 8'hEE;
      @(negedge clk);
    end
    bus.byte_dat = b;
    bus.byte_vld = 1'b1;
    t = 0;
    while (!bus.byte_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("rdy_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.byte_vld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] hdr, input logic [7:0] csum,
                          input int gapmax, input bit poke_start);
    wr_addr_q.delete();
    wr_dat_q.delete();
    wr_viol = 0;
    pulse_start();
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    send_byte(hdr, $urandom_range(0, gapmax));
    if (poke_start) pulse_start();
    foreach (payload_q[i]) send_byte(payload_q[i], $urandom_range(0, gapmax));
    send_byte(csum, $urandom_range(0, gapmax));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_addr_q.size(), exp_addr_q.size());
    check({tag, "_rdy_in_write"}, wr_viol, 32'd0);
    foreach (exp_addr_q[i]) begin
      if (i < wr_addr_q.size()) begin
        check({tag, "_addr"}, {24'd0, wr_addr_q[i]}, {24'd0, exp_addr_q[i]});
        check({tag, "_data"}, {8'd0, wr_dat_q[i]}, {8'd0, exp_dat_q[i]});
      end
    end
  endtask

  task automatic check_status(input string tag, input bit d, input bit e);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_err"},  {31'd0, err},  {31'd0, e});
    check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !d});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_rdy"},  {31'd0, bus.byte_rdy}, 32'd0);
  endtask

  task automatic set_two_word();
    payload_q = '{8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02, 8'h03};
    exp_addr_q = '{8'h00, 8'h01};
    exp_dat_q  = '{24'hAABBCC, 24'h010203};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   {31'd0, bus.byte_rdy}, 32'd0);
    check({tag, "_wren"},  {31'd0, bus.im_wr_en}, 32'd0);
    check({tag, "_addr"},  {24'd0, bus.im_addr}, 32'd0);
    check({tag, "_wdat"},  {8'd0, bus.im_wr_dat}, 32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_err"},   {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] cs;
    rst_n = 1'b0;
    start = 1'b0;
    bus.byte_vld = 1'b0;
    bus.byte_dat = 8'h00;
    wr_viol = 0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    // Single word, good checksum: 12^34^56 = 70
    payload_q  = '{8'h12, 8'h34, 8'h56};
    exp_addr_q = '{8'h00};
    exp_dat_q  = '{24'h123456};
    run_load(8'h01, 8'h70, 0, 1'b0);
    check_writes("one");
    check_status("one", 1'b1, 1'b0);

    // Two words back to back: AA^BB^CC^01^02^03 = DD
    set_two_word();
    run_load(8'h02, 8'hDD, 0, 1'b0);
    check_writes("two");
    check_status("two", 1'b1, 1'b0);
    check("two_addr_end", {24'd0, bus.im_addr}, 32'd2);

    // Bad checksum still writes, then flags err
    payload_q  = '{8'h12, 8'h34, 8'h56};
    exp_addr_q = '{8'h00};
    exp_dat_q  = '{24'h123456};
    run_load(8'h01, 8'h71, 0, 1'b0);
    check_writes("bad");
    check_status("bad", 1'b0, 1'b1);

    // Reload from ERR
    run_load(8'h01, 8'h70, 0, 1'b0);
    check_writes("reload");
    check_status("reload", 1'b1, 1'b0);

    // Header 0 -> 256 words, payload byte k = (k+1) mod 256
    payload_q.delete();
    exp_addr_q.delete();
    exp_dat_q.delete();
    cs = 8'h00;
    for (int k = 0; k < 768; k++) begin
      b = 8'(k + 1);
      payload_q.push_back(b);
      cs = cs ^ b;
    end
    for (int w = 0; w < 256; w++) begin
      exp_addr_q.push_back(8'(w));
      exp_dat_q.push_back({8'(3*w + 1), 8'(3*w + 2), 8'(3*w + 3)});
    end
    check("wrap_csum_model", {24'd0, cs}, 32'd0);
    run_load(8'h00, 8'h00, 0, 1'b0);
    check_writes("wrap");
    check_status("wrap", 1'b1, 1'b0);
    check("wrap_addr_end", {24'd0, bus.im_addr}, 32'd0);

    // Random valid gaps plus a start while busy
    set_two_word();
    run_load(8'h02, 8'hDD, 3, 1'b1);
    check_writes("gap");
    check_status("gap", 1'b1, 1'b0);

    // Reset mid-stream after HDR and B2 transfers
    wr_addr_q.delete();
    wr_dat_q.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.byte_dat = 8'h55;
    bus.byte_vld = 1'b1;
    repeat (6) @(negedge clk);
    bus.byte_vld = 1'b0;
    check_reset_outputs("post_rst");
    check("post_rst_nwr", wr_addr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
